sdram_ch_arbiter: RTL and testbench

//   Picks which channel FIFO is drained into SDRAM next. Scans all per-channel fill

---
 rtl/sdram_arb_pkg.sv | 25 ++
 rtl/sdram_ch_arbiter_rr_pick.sv | 31 +++
 rtl/sdram_ch_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sdram_ch_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM channel arbiter and the write-path select muxes.
// Holds the default geometry, the arbiter state encoding and the rotating-distance helper.
package sdram_arb_pkg;

   localparam int DEF_NUM_CH    = 10;
   localparam int DEF_USEDW_W   = 15;
   localparam int DEF_CH_W      = 8;
   localparam int DEF_BURST_LEN = 256;
   localparam int DEF_GAP_CYC   = 2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SCAN = 3'd1,
      ST_REQ  = 3'd2,
      ST_BUSY = 3'd3,
      ST_GAP  = 3'd4
   } arb_state_t;

   // Distance from the round-robin start to channel idx, walking upward and wrapping.
   function automatic int rr_dist(input int idx, input int start, input int n);
      if (idx >= start) return idx - start;
      else              return idx + n - start;
   endfunction

endpackage

// File: rtl/sdram_ch_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set bit of elig at or above start,
// wrapping from NUM_CH-1 back to 0. Purely combinational.
module rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int CH_W   = DEF_CH_W
) (
   input  logic [NUM_CH-1:0] elig,
   input  logic [CH_W-1:0]   start,
   output logic              hit,
   output logic [CH_W-1:0]   idx
);

   int best_dist;

   // Keep the eligible channel with the smallest wrapped distance from start.
   always_comb begin
      hit       = 1'b0;
      idx       = '0;
      best_dist = NUM_CH;
      for (int i = 0; i < NUM_CH; i++) begin
         if (elig[i] && (rr_dist(i, int'(start), NUM_CH) < best_dist)) begin
            best_dist = rr_dist(i, int'(start), NUM_CH);
            hit       = 1'b1;
            idx       = CH_W'(i);
         end
      end
   end

endmodule

// File: rtl/sdram_ch_arbiter.sv
// Channel arbiter for the SDRAM write path: picks the next FIFO to drain with
// round-robin fairness and runs the req/ack/done handshake with the write controller.
// Optional build macro SDRAM_ARB_FLUSH_EN adds the flush input, which lets partially
// filled channels be drained when no channel holds a full burst.
//
// state | meaning
// IDLE  | SDRAM controller not initialised, nothing issued
// SCAN  | compare fill levels every cycle, latch first eligible channel
// REQ   | wr_req high, waiting for wr_ack
// BUSY  | burst accepted, waiting for wr_done
// GAP   | settle time after a burst before scanning again
module sdram_ch_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int USEDW_W   = DEF_USEDW_W,
   parameter int CH_W      = DEF_CH_W,
   parameter int BURST_LEN = DEF_BURST_LEN,
   parameter int GAP_CYC   = DEF_GAP_CYC
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      init_done,
   input  logic [NUM_CH*USEDW_W-1:0] usedw_all,
   output logic                      wr_req,
   input  logic                      wr_ack,
   input  logic                      wr_done,
`ifdef SDRAM_ARB_FLUSH_EN
   input  logic                      flush,
`endif
   output logic [CH_W-1:0]           channel,
   output logic [USEDW_W-1:0]        burst_len,
   output logic                      busy
);

   localparam int                 GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYC - 1);
   localparam logic [USEDW_W-1:0] FULL_LVL = USEDW_W'(BURST_LEN);
   localparam logic [CH_W-1:0]    LAST_CH  = CH_W'(NUM_CH - 1);

   arb_state_t          state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [USEDW_W-1:0]  blen_q, blen_d;
   logic [CH_W-1:0]     rr_q, rr_d;
   logic [GAP_W-1:0]    gap_q, gap_d;

   logic [USEDW_W-1:0]  usedw_arr [NUM_CH];
   logic [NUM_CH-1:0]   elig_full;
   logic [NUM_CH-1:0]   pick_vec;
   logic                pick_hit;
   logic [CH_W-1:0]     pick_idx;
   logic [USEDW_W-1:0]  hit_len;
   logic [CH_W-1:0]     next_rr;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lvl
      assign usedw_arr[g] = usedw_all[g*USEDW_W +: USEDW_W];
      assign elig_full[g] = (usedw_arr[g] >= FULL_LVL);
   end

`ifdef SDRAM_ARB_FLUSH_EN
   logic [NUM_CH-1:0]   elig_any;
   logic [USEDW_W-1:0]  pick_lvl;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_any
      assign elig_any[g] = (usedw_arr[g] != '0);
   end

   // Full bursts always take precedence; partial channels only compete under flush.
   assign pick_vec = (|elig_full) ? elig_full : (flush ? elig_any : '0);

   // Fill level of the picked channel, used as the length of a partial burst.
   always_comb begin
      pick_lvl = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pick_idx == CH_W'(i)) pick_lvl = usedw_arr[i];
      end
   end

   assign hit_len = (|elig_full) ? FULL_LVL : pick_lvl;
`else
   assign pick_vec = elig_full;
   assign hit_len  = FULL_LVL;
`endif

   rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_rr_pick (
      .elig  (pick_vec),
      .start (rr_q),
      .hit   (pick_hit),
      .idx   (pick_idx)
   );

   assign next_rr = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);

   // Next-state logic; a finished burst goes to IDLE rather than GAP if init_done dropped.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      blen_d  = blen_q;
      rr_d    = rr_q;
      gap_d   = gap_q;
      case (state_q)
         ST_IDLE: begin
            if (init_done) state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (!init_done) begin
               state_d = ST_IDLE;
            end else if (pick_hit) begin
               ch_d    = pick_idx;
               blen_d  = hit_len;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (wr_ack) begin
               if (wr_done) begin
                  rr_d    = next_rr;
                  gap_d   = GAP_LOAD;
                  state_d = init_done ? ST_GAP : ST_IDLE;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            if (wr_done) begin
               rr_d    = next_rr;
               gap_d   = GAP_LOAD;
               state_d = init_done ? ST_GAP : ST_IDLE;
            end
         end
         ST_GAP: begin
            if (!init_done)         state_d = ST_IDLE;
            else if (gap_q == '0)   state_d = ST_SCAN;
            else                    gap_d   = gap_q - GAP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
         blen_q  <= '0;
         rr_q    <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         blen_q  <= blen_d;
         rr_q    <= rr_d;
         gap_q   <= gap_d;
      end
   end

   assign wr_req    = (state_q == ST_REQ);
   assign busy      = (state_q == ST_REQ) || (state_q == ST_BUSY);
   assign channel   = ch_q;
   assign burst_len = blen_q;

endmodule

// File: tb/tb_sdram_ch_arbiter.sv
// Directed bench for sdram_ch_arbiter with default parameters (10 channels, 15-bit levels,
// 256-word bursts, 2-cycle gap). Flush checks are built only with SDRAM_ARB_FLUSH_EN.
module tb_sdram_ch_arbiter;

   localparam int NCH = 10;
   localparam int UW  = 15;

   typedef struct {
      logic [NCH*UW-1:0] usedw;
      int                exp_ch;
      int                exp_blen;
      int                exp_lat;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              init_done;
   logic [NCH*UW-1:0] usedw_all;
   logic              wr_req;
   logic              wr_ack;
   logic              wr_done;
   logic              flush;
   logic [7:0]        channel;
   logic [UW-1:0]     burst_len;
   logic              busy;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t tbl [9];

   always #5 clk = ~clk;

   sdram_ch_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .init_done (init_done),
      .usedw_all (usedw_all),
      .wr_req    (wr_req),
      .wr_ack    (wr_ack),
      .wr_done   (wr_done),
`ifdef SDRAM_ARB_FLUSH_EN
      .flush     (flush),
`endif
      .channel   (channel),
      .burst_len (burst_len),
      .busy      (busy)
   );

   function automatic logic [NCH*UW-1:0] mk(input int a, input int av, input int b, input int bv);
      logic [NCH*UW-1:0] u;
      u = '0;
      for (int i = 0; i < NCH; i++) begin
         if (i == a) u[i*UW +: UW] = UW'(av);
         if (i == b) u[i*UW +: UW] = UW'(bv);
      end
      return u;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Counts negedges until wr_req is seen, bounded.
   task automatic wait_req(output int lat);
      lat = 0;
      while (!wr_req && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic pulse_ack();
      wr_ack = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0;
   endtask

   task automatic pulse_done();
      wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
   endtask

   task automatic count_req(input int cycles, output int hits);
      hits = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (wr_req) hits++;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int hits;

      rst = 1'b1; init_done = 1'b0; usedw_all = '0;
      wr_ack = 1'b0; wr_done = 1'b0; flush = 1'b0;

      tbl[0] = '{mk(2, 300, 7, 300),   2, 256, 2};
      tbl[1] = '{mk(2, 300, 7, 300),   7, 256, 3};
      tbl[2] = '{mk(2, 300, 7, 300),   2, 256, 3};
      tbl[3] = '{mk(3, 256, -1, 0),    3, 256, 3};
      tbl[4] = '{mk(3, 256, 5, 256),   5, 256, 3};
      tbl[5] = '{mk(9, 256, 0, 1000),  9, 256, 3};
      tbl[6] = '{mk(9, 256, 0, 1000),  0, 256, 3};
      tbl[7] = '{mk(0, 256, 1, 255),   0, 256, 3};
      tbl[8] = '{mk(1, 32767, 0, 256), 1, 256, 3};

      repeat (3) @(negedge clk);
      check("rst_wr_req", int'(wr_req), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_channel", int'(channel), 0);
      check("rst_burst_len", int'(burst_len), 0);
      rst = 1'b0;
      init_done = 1'b1;

      for (int v = 0; v < 9; v++) begin
         usedw_all = tbl[v].usedw;
         wait_req(lat);
         check($sformatf("v%0d_req", v), int'(wr_req), 1);
         check($sformatf("v%0d_latency", v), lat, tbl[v].exp_lat);
         check($sformatf("v%0d_channel", v), int'(channel), tbl[v].exp_ch);
         check($sformatf("v%0d_burst_len", v), int'(burst_len), tbl[v].exp_blen);
         check($sformatf("v%0d_busy_req", v), int'(busy), 1);
         pulse_ack();
         usedw_all = '0;
         check($sformatf("v%0d_req_drop", v), int'(wr_req), 0);
         check($sformatf("v%0d_busy_hold", v), int'(busy), 1);
         @(negedge clk);
         check($sformatf("v%0d_channel_stable", v), int'(channel), tbl[v].exp_ch);
         check($sformatf("v%0d_blen_stable", v), int'(burst_len), tbl[v].exp_blen);
         pulse_done();
         check($sformatf("v%0d_busy_gap", v), int'(busy), 0);
      end

      // One word short of a burst never qualifies; reaching the threshold does, next cycle.
      usedw_all = mk(5, 255, -1, 0);
      count_req(20, hits);
      check("below_thresh_no_req", hits, 0);
      usedw_all = mk(5, 256, -1, 0);
      wait_req(lat);
      check("thresh_latency", lat, 1);
      check("thresh_channel", int'(channel), 5);

      // ack and done together in REQ: straight to GAP, next request after the gap.
      wr_ack = 1'b1; wr_done = 1'b1;
      @(negedge clk);
      wr_ack = 1'b0; wr_done = 1'b0;
      check("ackdone_busy", int'(busy), 0);
      check("ackdone_req", int'(wr_req), 0);
      wait_req(lat);
      check("ackdone_gap_latency", lat, 3);
      check("ackdone_channel", int'(channel), 5);
      pulse_ack();
      pulse_done();

      // init_done dropped mid-burst: burst completes, then arbiter parks in IDLE.
      usedw_all = mk(7, 256, -1, 0);
      wait_req(lat);
      check("initdrop_latency", lat, 3);
      check("initdrop_channel", int'(channel), 7);
      pulse_ack();
      init_done = 1'b0;
      @(negedge clk);
      check("initdrop_busy_hold", int'(busy), 1);
      pulse_done();
      count_req(10, hits);
      check("initdrop_no_req", hits, 0);
      check("initdrop_idle_busy", int'(busy), 0);
      init_done = 1'b1;
      wait_req(lat);
      check("reinit_latency", lat, 2);
      check("reinit_channel", int'(channel), 7);
      pulse_ack();

      // Reset during BUSY clears everything, including the round-robin pointer.
      rst = 1'b1;
      @(negedge clk);
      check("midrst_wr_req", int'(wr_req), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_channel", int'(channel), 0);
      check("midrst_burst_len", int'(burst_len), 0);
      rst = 1'b0;
      usedw_all = mk(2, 256, 8, 256);
      wait_req(lat);
      check("postrst_latency", lat, 2);
      check("postrst_channel", int'(channel), 2);
      pulse_ack();
      pulse_done();

`ifdef SDRAM_ARB_FLUSH_EN
      flush = 1'b1;
      usedw_all = mk(6, 17, -1, 0);
      wait_req(lat);
      check("flush_req", int'(wr_req), 1);
      check("flush_channel", int'(channel), 6);
      check("flush_burst_len", int'(burst_len), 17);
      pulse_ack();
      pulse_done();
      usedw_all = mk(6, 17, 1, 256);
      wait_req(lat);
      check("flush_full_first_ch", int'(channel), 1);
      check("flush_full_first_len", int'(burst_len), 256);
      pulse_ack();
      pulse_done();
      flush = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
